// File: rtl/lsu_stbuf_queue.sv
// LSU store buffer: coalescing FIFO of committed stores that drains to the
// DCCM/PIC arbiter and forwards bytes to in-flight loads.
module lsu_stbuf_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      st_wr_en,
  input  logic [ADDR_W-1:0]         st_wr_addr,
  input  logic [DATA_W-1:0]         st_wr_data,
  input  logic [DATA_W/8-1:0]       st_wr_byteen,
  input  logic                      st_wr_in_pic,
  input  logic                      lsu_stbuf_commit_any,
  input  logic                      ld_fwd_en_dc2,
  input  logic [ADDR_W-1:0]         ld_addr_lo_dc2,
  input  logic [ADDR_W-1:0]         ld_addr_hi_dc2,
  output logic                      stbuf_reqvld_any,
  output logic [ADDR_W-1:0]         stbuf_addr_any,
  output logic [DATA_W-1:0]         stbuf_data_any,
  output logic [DATA_W/8-1:0]       stbuf_byteen_any,
  output logic                      stbuf_addr_in_pic_any,
  output logic [DATA_W-1:0]         stbuf_fwddata_lo_dc3,
  output logic [DATA_W-1:0]         stbuf_fwddata_hi_dc3,
  output logic [DATA_W/8-1:0]       stbuf_fwdbyteen_lo_dc3,
  output logic [DATA_W/8-1:0]       stbuf_fwdbyteen_hi_dc3,
  output logic                      stbuf_full,
  output logic                      stbuf_empty,
  output logic [$clog2(DEPTH):0]    stbuf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_W / 8;
  localparam int TW = ADDR_W - 2;

  logic          vld_q  [DEPTH];
  logic [TW-1:0] tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BW-1:0] be_q   [DEPTH];
  logic          pic_q  [DEPTH];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] flo_q, flo_d;
  logic [DATA_W-1:0] fhi_q, fhi_d;
  logic [BW-1:0]     fblo_q, fblo_d;
  logic [BW-1:0]     fbhi_q, fbhi_d;

  logic [PW-1:0] young;
  logic [PW-1:0] ord [DEPTH];
  logic [TW-1:0] st_tag, lo_tag, hi_tag;
  logic [DATA_W-1:0] mdata;
  logic pop, hit, alloc, full;
  logic unused_lsb;

  assign unused_lsb = ^{st_wr_addr[1:0], ld_addr_lo_dc2[1:0],
                        ld_addr_hi_dc2[1:0]};

  assign st_tag = st_wr_addr[ADDR_W-1:2];
  assign lo_tag = ld_addr_lo_dc2[ADDR_W-1:2];
  assign hi_tag = ld_addr_hi_dc2[ADDR_W-1:2];
  assign young  = wr_q - PW'(1);
  assign full   = (cnt_q == CW'(DEPTH));

  assign pop = lsu_stbuf_commit_any & vld_q[rd_q];

  // PIC stores are whole-register writes, so they never merge
  assign hit = st_wr_en & ~st_wr_in_pic
             & vld_q[young] & ~pic_q[young]
             & (tag_q[young] == st_tag)
             & ~(pop & (young == rd_q));

  assign alloc = st_wr_en & ~hit & (~full | pop);

  always_comb begin
    mdata = data_q[young];
    for (int b = 0; b < BW; b++) begin
      if (st_wr_byteen[b]) mdata[8*b +: 8] = st_wr_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(alloc);
    cnt_d = cnt_q + CW'(alloc) - CW'(pop);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord[i] = rd_q + PW'(i);
    end
  end

  // Walk oldest to youngest so the youngest hit per byte wins
  always_comb begin
    flo_d  = '0;
    fhi_d  = '0;
    fblo_d = '0;
    fbhi_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < BW; b++) begin
        if (ld_fwd_en_dc2 & vld_q[ord[i]] & ~pic_q[ord[i]]
            & be_q[ord[i]][b]) begin
          if (tag_q[ord[i]] == lo_tag) begin
            flo_d[8*b +: 8] = data_q[ord[i]][8*b +: 8];
            fblo_d[b]       = 1'b1;
          end
          if (tag_q[ord[i]] == hi_tag) begin
            fhi_d[8*b +: 8] = data_q[ord[i]][8*b +: 8];
            fbhi_d[b]       = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        pic_q[i]  <= 1'b0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      flo_q  <= '0;
      fhi_q  <= '0;
      fblo_q <= '0;
      fbhi_q <= '0;
    end else begin
      if (pop) vld_q[rd_q] <= 1'b0;
      if (hit) begin
        data_q[young] <= mdata;
        be_q[young]   <= be_q[young] | st_wr_byteen;
      end
      // Full+pop+alloc reuses the popped slot; the set below wins
      if (alloc) begin
        vld_q[wr_q]  <= 1'b1;
        tag_q[wr_q]  <= st_tag;
        data_q[wr_q] <= st_wr_data;
        be_q[wr_q]   <= st_wr_byteen;
        pic_q[wr_q]  <= st_wr_in_pic;
      end
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      flo_q  <= flo_d;
      fhi_q  <= fhi_d;
      fblo_q <= fblo_d;
      fbhi_q <= fbhi_d;
    end
  end

  assign stbuf_reqvld_any      = vld_q[rd_q];
  assign stbuf_addr_any        = vld_q[rd_q] ? {tag_q[rd_q], 2'b00} : '0;
  assign stbuf_data_any        = vld_q[rd_q] ? data_q[rd_q] : '0;
  assign stbuf_byteen_any      = vld_q[rd_q] ? be_q[rd_q] : '0;
  assign stbuf_addr_in_pic_any = vld_q[rd_q] & pic_q[rd_q];

  assign stbuf_fwddata_lo_dc3   = flo_q;
  assign stbuf_fwddata_hi_dc3   = fhi_q;
  assign stbuf_fwdbyteen_lo_dc3 = fblo_q;
  assign stbuf_fwdbyteen_hi_dc3 = fbhi_q;

  assign stbuf_count = cnt_q;
  assign stbuf_full  = full;
  assign stbuf_empty = (cnt_q == '0);

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Directed vector bench for lsu_stbuf_queue: drain, coalesce, wrap,
// forwarding, PIC handling and asynchronous reset.
module tb_lsu_stbuf_queue;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        st_wr_en;
  logic [15:0] st_wr_addr;
  logic [31:0] st_wr_data;
  logic [3:0]  st_wr_byteen;
  logic        st_wr_in_pic;
  logic        lsu_stbuf_commit_any;
  logic        ld_fwd_en_dc2;
  logic [15:0] ld_addr_lo_dc2;
  logic [15:0] ld_addr_hi_dc2;
  logic        stbuf_reqvld_any;
  logic [15:0] stbuf_addr_any;
  logic [31:0] stbuf_data_any;
  logic [3:0]  stbuf_byteen_any;
  logic        stbuf_addr_in_pic_any;
  logic [31:0] stbuf_fwddata_lo_dc3;
  logic [31:0] stbuf_fwddata_hi_dc3;
  logic [3:0]  stbuf_fwdbyteen_lo_dc3;
  logic [3:0]  stbuf_fwdbyteen_hi_dc3;
  logic        stbuf_full;
  logic        stbuf_empty;
  logic [2:0]  stbuf_count;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  lsu_stbuf_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .st_wr_en               (st_wr_en),
    .st_wr_addr             (st_wr_addr),
    .st_wr_data             (st_wr_data),
    .st_wr_byteen           (st_wr_byteen),
    .st_wr_in_pic           (st_wr_in_pic),
    .lsu_stbuf_commit_any   (lsu_stbuf_commit_any),
    .ld_fwd_en_dc2          (ld_fwd_en_dc2),
    .ld_addr_lo_dc2         (ld_addr_lo_dc2),
    .ld_addr_hi_dc2         (ld_addr_hi_dc2),
    .stbuf_reqvld_any       (stbuf_reqvld_any),
    .stbuf_addr_any         (stbuf_addr_any),
    .stbuf_data_any         (stbuf_data_any),
    .stbuf_byteen_any       (stbuf_byteen_any),
    .stbuf_addr_in_pic_any  (stbuf_addr_in_pic_any),
    .stbuf_fwddata_lo_dc3   (stbuf_fwddata_lo_dc3),
    .stbuf_fwddata_hi_dc3   (stbuf_fwddata_hi_dc3),
    .stbuf_fwdbyteen_lo_dc3 (stbuf_fwdbyteen_lo_dc3),
    .stbuf_fwdbyteen_hi_dc3 (stbuf_fwdbyteen_hi_dc3),
    .stbuf_full             (stbuf_full),
    .stbuf_empty            (stbuf_empty),
    .stbuf_count            (stbuf_count)
  );

  typedef struct {
    bit        we;
    bit [15:0] a;
    bit [31:0] d;
    bit [3:0]  be;
    bit        pic;
    bit        cm;
    bit        fe;
    bit [15:0] lo;
    bit [15:0] hi;
    bit        xv;
    bit [15:0] xa;
    bit [31:0] xd;
    bit [3:0]  xbe;
    bit        xpic;
    bit [2:0]  xc;
    bit [31:0] xflo;
    bit [3:0]  xblo;
    bit [31:0] xfhi;
    bit [3:0]  xbhi;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    bit we, bit [15:0] a, bit [31:0] d, bit [3:0] be, bit pic,
    bit cm, bit fe, bit [15:0] lo, bit [15:0] hi,
    bit xv, bit [15:0] xa, bit [31:0] xd, bit [3:0] xbe, bit xpic,
    bit [2:0] xc, bit [31:0] xflo, bit [3:0] xblo,
    bit [31:0] xfhi, bit [3:0] xbhi);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.be = be; v.pic = pic;
    v.cm = cm; v.fe = fe; v.lo = lo; v.hi = hi;
    v.xv = xv; v.xa = xa; v.xd = xd; v.xbe = xbe; v.xpic = xpic;
    v.xc = xc; v.xflo = xflo; v.xblo = xblo;
    v.xfhi = xfhi; v.xbhi = xbhi;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle();
    st_wr_en = 0; st_wr_addr = '0; st_wr_data = '0;
    st_wr_byteen = '0; st_wr_in_pic = 0;
    lsu_stbuf_commit_any = 0; ld_fwd_en_dc2 = 0;
    ld_addr_lo_dc2 = '0; ld_addr_hi_dc2 = '0;
  endtask

  task automatic drive(vec_t v);
    st_wr_en = v.we; st_wr_addr = v.a; st_wr_data = v.d;
    st_wr_byteen = v.be; st_wr_in_pic = v.pic;
    lsu_stbuf_commit_any = v.cm; ld_fwd_en_dc2 = v.fe;
    ld_addr_lo_dc2 = v.lo; ld_addr_hi_dc2 = v.hi;
  endtask

  task automatic chk_head(string p, bit v, bit [15:0] a, bit [31:0] d,
                          bit [3:0] be, bit pic, bit [2:0] c);
    chk({p, ".vld"}, stbuf_reqvld_any, v);
    chk({p, ".addr"}, stbuf_addr_any, a);
    chk({p, ".data"}, stbuf_data_any, d);
    chk({p, ".be"}, stbuf_byteen_any, be);
    chk({p, ".pic"}, stbuf_addr_in_pic_any, pic);
    chk({p, ".cnt"}, stbuf_count, c);
    chk({p, ".full"}, stbuf_full, c == 3'd4);
    chk({p, ".empty"}, stbuf_empty, c == 3'd0);
  endtask

  task automatic chk_vec(int i, vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    chk_head(p, v.xv, v.xa, v.xd, v.xbe, v.xpic, v.xc);
    chk({p, ".flo"}, stbuf_fwddata_lo_dc3, v.xflo);
    chk({p, ".fblo"}, stbuf_fwdbyteen_lo_dc3, v.xblo);
    chk({p, ".fhi"}, stbuf_fwddata_hi_dc3, v.xfhi);
    chk({p, ".fbhi"}, stbuf_fwdbyteen_hi_dc3, v.xbhi);
  endtask

  task automatic store(bit [15:0] a, bit [31:0] d);
    @(negedge clk);
    idle();
    st_wr_en = 1; st_wr_addr = a; st_wr_data = d; st_wr_byteen = 4'hF;
    @(posedge clk);
    #1;
  endtask

  // Overfilling without a pop or merge is an upstream protocol error
  always @(posedge clk) begin
    if (rst_l && st_wr_en && stbuf_full && !lsu_stbuf_commit_any)
      assert (0) else $error("store issued into full buffer");
  end

  initial begin
    idle();
    rst_l = 0;
    // we a d be pic cm fe lo hi | xv xa xd xbe xpic xc flo blo fhi bhi
    vq.push_back(mk(1,'h0100,'hAABBCCDD,'hF,0,0,0,0,0,
                    1,'h0100,'hAABBCCDD,'hF,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                    1,'h0100,'hAABBCCDD,'hF,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h0204,'h00000011,'h1,0,0,0,0,0,
                    1,'h0204,'h00000011,'h1,0,1,0,0,0,0));
    vq.push_back(mk(1,'h0206,'h00330000,'h4,0,0,0,0,0,
                    1,'h0204,'h00330011,'h5,0,1,0,0,0,0));
    vq.push_back(mk(1,'h0204,'h00004400,'h2,0,1,0,0,0,
                    1,'h0204,'h00004400,'h2,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h0400,'h04040404,'hF,0,0,0,0,0,
                    1,'h0400,'h04040404,'hF,0,1,0,0,0,0));
    vq.push_back(mk(1,'h0500,'h05050505,'hF,0,0,0,0,0,
                    1,'h0400,'h04040404,'hF,0,2,0,0,0,0));
    vq.push_back(mk(1,'h0600,'h06060606,'hF,0,0,0,0,0,
                    1,'h0400,'h04040404,'hF,0,3,0,0,0,0));
    vq.push_back(mk(1,'h0700,'h07070707,'hF,0,0,0,0,0,
                    1,'h0400,'h04040404,'hF,0,4,0,0,0,0));
    vq.push_back(mk(1,'h0800,'h08080808,'hF,0,1,1,'h0400,'h0800,
                    1,'h0500,'h05050505,'hF,0,4,'h04040404,'hF,0,0));
    vq.push_back(mk(0,0,0,0,0,1,1,'h0800,'h0500,
                    1,'h0600,'h06060606,'hF,0,3,
                    'h08080808,'hF,'h05050505,'hF));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0,
                    1,'h0700,'h07070707,'hF,0,2,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0,
                    1,'h0800,'h08080808,'hF,0,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h0300,'h11111111,'hF,0,0,0,0,0,
                    1,'h0300,'h11111111,'hF,0,1,0,0,0,0));
    vq.push_back(mk(1,'h0310,'h31313131,'hF,0,0,0,0,0,
                    1,'h0300,'h11111111,'hF,0,2,0,0,0,0));
    vq.push_back(mk(1,'h0300,'h22220000,'hC,0,0,0,0,0,
                    1,'h0300,'h11111111,'hF,0,3,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,'h0300,'h0310,
                    1,'h0300,'h11111111,'hF,0,3,
                    'h22221111,'hF,'h31313131,'hF));
    vq.push_back(mk(0,0,0,0,0,1,0,'h0300,'h0310,
                    1,'h0310,'h31313131,'hF,0,2,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,1,'h0302,'h0300,
                    1,'h0300,'h22220000,'hC,0,1,
                    'h22220000,'hC,'h22220000,'hC));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,'h3000,'h000000AB,'hF,1,0,0,0,0,
                    1,'h3000,'h000000AB,'hF,1,1,0,0,0,0));
    vq.push_back(mk(1,'h3000,'h000000CD,'hF,1,0,1,'h3000,'h3000,
                    1,'h3000,'h000000AB,'hF,1,2,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0,
                    1,'h3000,'h000000CD,'hF,1,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,0));

    #12;
    chk_head("rst", 0, 0, 0, 0, 0, 0);
    chk("rst.flo", stbuf_fwddata_lo_dc3, 0);
    chk("rst.fblo", stbuf_fwdbyteen_lo_dc3, 0);
    @(negedge clk);
    rst_l = 1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_vec(i, vq[i]);
    end

    // Asynchronous reset with three entries queued
    store('h0A00, 'h12345678);
    store('h0A04, 'h9ABCDEF0);
    @(negedge clk);
    idle();
    st_wr_en = 1; st_wr_addr = 'h0A08; st_wr_data = 'h0F0F0F0F;
    st_wr_byteen = 4'hF;
    ld_fwd_en_dc2 = 1; ld_addr_lo_dc2 = 'h0A00;
    @(posedge clk);
    #1;
    chk_head("pre", 1, 'h0A00, 'h12345678, 'hF, 0, 3);
    chk("pre.flo", stbuf_fwddata_lo_dc3, 'h12345678);
    @(negedge clk);
    idle();
    rst_l = 0;
    #1;
    chk_head("arst", 0, 0, 0, 0, 0, 0);
    chk("arst.flo", stbuf_fwddata_lo_dc3, 0);
    chk("arst.fblo", stbuf_fwdbyteen_lo_dc3, 0);
    @(negedge clk);
    rst_l = 1;

    store('h0B00, 'hCAFEF00D);
    chk_head("post0", 1, 'h0B00, 'hCAFEF00D, 'hF, 0, 1);
    store('h0B04, 'h0000B004);
    store('h0B08, 'h0000B008);
    store('h0B0C, 'h0000B00C);
    chk_head("post3", 1, 'h0B00, 'hCAFEF00D, 'hF, 0, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      chk($sformatf("drain%0d", k), stbuf_addr_any, 16'h0B00 + 16'(4*k));
      lsu_stbuf_commit_any = 1;
      @(posedge clk);
      #1;
    end
    chk_head("drained", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    idle();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
